// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: multi-cycle MULT/DIV unit that owns the Hi/Lo registers.
// One add/subtract per cycle serves both shift-add multiply and restoring divide.
// Ports: Clk, Reset (async, active-low), Start/Op/A/B (op from EX),
//   HiLoRead (mfhi/mflo in ID), HiWrite/LoWrite/WData (mthi/mtlo),
//   Hi_reg/Lo_reg (architectural Hi/Lo), Busy, Stall, Done (1-cycle pulse),
//   DivByZero (last completed op was a divide by zero).
// Optional: define MULDIV_ACC_EN to enable MADD (Op 100) and MSUB (Op 101).
module hilo_muldiv_sequencer #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] DBZ_LO = {WIDTH{1'b1}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoRead,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WData,
    output logic [WIDTH-1:0] Hi_reg,
    output logic [WIDTH-1:0] Lo_reg,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_hi_reg;
    logic [WIDTH-1:0] r_lo_reg;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_is_dbz;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;
    logic             r_dbz_flag;

    logic             w_valid;
    logic             w_signed;
    logic             w_div;
    logic             w_dbz;
    logic             w_accept;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_mode_mul;
    logic [WIDTH:0]   w_opa;
    logic [WIDTH:0]   w_opb;
    logic [WIDTH:0]   w_sum;
    logic             w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

`ifdef MULDIV_ACC_EN
    logic             w_acc;
    logic             w_sub;
    logic             r_is_acc;
    logic             r_is_sub;
    logic [2*WIDTH-1:0] w_acc_res;
`endif

    // Op decode
    always_comb begin
        w_valid  = 1'b0;
        w_signed = 1'b0;
        w_div    = 1'b0;
`ifdef MULDIV_ACC_EN
        w_acc    = 1'b0;
        w_sub    = 1'b0;
`endif
        case (Op)
            3'b000: begin
                w_valid  = 1'b1;
                w_signed = 1'b1;
            end
            3'b001: w_valid = 1'b1;
            3'b010: begin
                w_valid  = 1'b1;
                w_signed = 1'b1;
                w_div    = 1'b1;
            end
            3'b011: begin
                w_valid = 1'b1;
                w_div   = 1'b1;
            end
`ifdef MULDIV_ACC_EN
            3'b100: begin
                w_valid  = 1'b1;
                w_signed = 1'b1;
                w_acc    = 1'b1;
            end
            3'b101: begin
                w_valid  = 1'b1;
                w_signed = 1'b1;
                w_acc    = 1'b1;
                w_sub    = 1'b1;
            end
`endif
            default: w_valid = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) & Start & w_valid;
    assign w_dbz    = w_div & (B == '0);
    assign w_abs_a  = (w_signed & A[WIDTH-1]) ? -A : A;
    assign w_abs_b  = (w_signed & B[WIDTH-1]) ? -B : B;

    // Shared adder: multiply adds the multiplicand to the upper half;
    // divide subtracts the divisor from the shifted partial remainder.
    assign w_mode_mul = (r_state == S_MUL);
    assign w_opa = w_mode_mul ? {1'b0, r_acc_hi}
                              : {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_opb = w_mode_mul ? {1'b0, r_opnd} : ~{1'b0, r_opnd};
    assign w_sum = w_opa + w_opb + {{WIDTH{1'b0}}, ~w_mode_mul};
    // Partial remainder < divisor, so bit WIDTH of the difference is the borrow.
    assign w_ge  = ~w_sum[WIDTH];

    assign w_prod = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quo  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem  = r_neg_r ? -r_acc_hi : r_acc_hi;

`ifdef MULDIV_ACC_EN
    assign w_acc_res = r_is_sub ? ({r_hi_reg, r_lo_reg} - w_prod)
                                : ({r_hi_reg, r_lo_reg} + w_prod);
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_dbz) begin
                        w_next = S_FIX;
                    end else if (w_div) begin
                        w_next = S_DIV;
                    end else begin
                        w_next = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hi_reg   <= '0;
            r_lo_reg   <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_is_dbz   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_done     <= 1'b0;
            r_dbz_flag <= 1'b0;
`ifdef MULDIV_ACC_EN
            r_is_acc   <= 1'b0;
            r_is_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (HiWrite) r_hi_reg <= WData;
                if (LoWrite) r_lo_reg <= WData;
            end
            if (w_accept) begin
                r_cnt      <= '0;
                r_dbz_flag <= 1'b0;
                r_is_div   <= w_div;
                r_is_dbz   <= w_dbz;
                r_neg_q    <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg_r    <= w_signed & A[WIDTH-1];
                r_acc_hi   <= '0;
                // Divide-by-zero keeps the raw dividend for Hi.
                r_acc_lo   <= w_div ? (w_dbz ? A : w_abs_a) : w_abs_b;
                r_opnd     <= w_div ? w_abs_b : w_abs_a;
`ifdef MULDIV_ACC_EN
                r_is_acc   <= w_acc;
                r_is_sub   <= w_sub;
`endif
            end
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_acc_lo[0]) begin
                        {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[WIDTH-1:1]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi,
                                                 r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_DIV: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc_hi <= w_ge ? w_sum[WIDTH-1:0]
                                     : {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_dbz) begin
                        r_hi_reg   <= r_acc_lo;
                        r_lo_reg   <= DBZ_LO;
                        r_dbz_flag <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi_reg <= w_rem;
                        r_lo_reg <= w_quo;
`ifdef MULDIV_ACC_EN
                    end else if (r_is_acc) begin
                        {r_hi_reg, r_lo_reg} <= w_acc_res;
`endif
                    end else begin
                        {r_hi_reg, r_lo_reg} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Hi_reg    = r_hi_reg;
    assign Lo_reg    = r_lo_reg;
    assign Busy      = (r_state != S_IDLE);
    assign Stall     = Busy & (HiLoRead | Start | HiWrite | LoWrite);
    assign Done      = r_done;
    assign DivByZero = r_dbz_flag;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed-vector bench for hilo_muldiv_sequencer.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_hilo_muldiv_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        HiLoRead = 1'b0;
    logic        HiWrite = 1'b0;
    logic        LoWrite = 1'b0;
    logic [31:0] WData = '0;
    logic [31:0] Hi_reg;
    logic [31:0] Lo_reg;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;

    int n_vec = 0;
    int n_err = 0;

    hilo_muldiv_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiLoRead(HiLoRead), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .WData(WData), .Hi_reg(Hi_reg), .Lo_reg(Lo_reg), .Busy(Busy),
        .Stall(Stall), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
        Op = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0;
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        int cyc;
        int stl;
        int seen;

        #1;
        check("rst_hilo", {Hi_reg, Lo_reg}, 64'd0);
        check("rst_flags", {Busy, Done, DivByZero, Stall}, 4'b0000);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        // 1: MULTU max * 2
        run(3'b001, 32'hFFFFFFFF, 32'd2, cyc);
        check("multu_busy", cyc, 33);
        check("multu_done", Done, 1'b1);
        check("multu_hilo", {Hi_reg, Lo_reg}, 64'h00000001_FFFFFFFE);
        tick();
        check("multu_done_pulse", Done, 1'b0);

        // 2: MULT signed, DIVU
        run(3'b000, -32'sd3, 32'd5, cyc);
        check("mult_hilo", {Hi_reg, Lo_reg}, 64'hFFFFFFFF_FFFFFFF1);
        run(3'b011, 32'd100, 32'd7, cyc);
        check("divu_hilo", {Hi_reg, Lo_reg}, {32'd2, 32'd14});

        // 3: DIV signed, overflow case
        run(3'b010, -32'sd7, 32'd2, cyc);
        check("div_neg_hilo", {Hi_reg, Lo_reg}, 64'hFFFFFFFF_FFFFFFFD);
        run(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("div_ovf_hilo", {Hi_reg, Lo_reg}, 64'h00000000_80000000);

        // 4: divide by zero
        run(3'b011, 32'd5, 32'd0, cyc);
        check("dbz_busy", cyc, 1);
        check("dbz_done", Done, 1'b1);
        check("dbz_hilo", {Hi_reg, Lo_reg}, 64'h00000005_FFFFFFFF);
        check("dbz_flag", DivByZero, 1'b1);
        tick();
        check("dbz_done_pulse", Done, 1'b0);
        Op = 3'b001; A = 32'd2; B = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("dbz_clear", DivByZero, 1'b0);
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("mul_2x3", Lo_reg, 32'd6);

        // 5a: mfhi/mtlo held while busy
        Op = 3'b001; A = 32'd3; B = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0; HiLoRead = 1'b1; LoWrite = 1'b1; WData = 32'hABCD;
        cyc = 0;
        stl = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            if (Stall) stl++;
            tick();
        end
        check("stall_cycles", stl, 33);
        check("stall_fix_lo", Lo_reg, 32'd9);
        check("stall_idle", Stall, 1'b0);
        tick();
        check("mtlo_after", Lo_reg, 32'hABCD);
        HiLoRead = 1'b0; LoWrite = 1'b0;

        // 5b: mthi on the accept edge, then overridden by FIX
        Op = 3'b001; A = 32'd1; B = 32'd1; Start = 1'b1;
        HiWrite = 1'b1; WData = 32'd55;
        tick();
        Start = 1'b0; HiWrite = 1'b0;
        check("mthi_accept", Hi_reg, 32'd55);
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("mthi_override", {Hi_reg, Lo_reg}, 64'd1);

        // 5c: Start held through a busy op
        Op = 3'b001; A = 32'd2; B = 32'd2; Start = 1'b1;
        tick();
        A = 32'd3; B = 32'd3;
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("held_first", Lo_reg, 32'd4);
        tick();
        check("held_accept", Busy, 1'b1);
        Start = 1'b0;
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check("held_second", Lo_reg, 32'd9);

        // invalid ops
        Op = 3'b110; Start = 1'b1;
        tick();
        check("op110_busy", Busy, 1'b0);
        Op = 3'b111;
        tick();
        Start = 1'b0;
        check("op111_busy", Busy, 1'b0);
        check("op_inv_done", Done, 1'b0);

`ifdef MULDIV_ACC_EN
        // 6: MADD / MSUB
        HiWrite = 1'b1; WData = 32'd0;
        tick();
        HiWrite = 1'b0; LoWrite = 1'b1; WData = 32'd10;
        tick();
        LoWrite = 1'b0;
        run(3'b100, 32'd3, 32'd4, cyc);
        check("madd_hilo", {Hi_reg, Lo_reg}, 64'd22);
        run(3'b101, 32'd5, 32'd5, cyc);
        check("msub_hilo", {Hi_reg, Lo_reg}, 64'hFFFFFFFF_FFFFFFFD);
`else
        Op = 3'b100; Start = 1'b1;
        tick();
        check("op100_busy", Busy, 1'b0);
        Op = 3'b101;
        tick();
        Start = 1'b0;
        check("op101_busy", Busy, 1'b0);
`endif

        // 5d: reset in the middle of a multiply
        Op = 3'b001; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        check("mid_busy", Busy, 1'b1);
        Reset = 1'b0;
        #1;
        check("mid_rst_hilo", {Hi_reg, Lo_reg}, 64'd0);
        check("mid_rst_flags", {Busy, Done, DivByZero}, 3'b000);
        tick();
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) seen = 1;
            tick();
        end
        check("mid_rst_quiet", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
